// File: rtl/efpga_pwr_seq_pkg.sv
// Shared types and constants for the eFPGA reset/enable sequencer.
`timescale 1ns/1ps
package efpga_seq_pkg;

  localparam int NUM_EFPGA_RST = 4;
  localparam int NUM_EFPGA_EN  = 7;

  // Bit positions inside the enable vector
  localparam int EN_TCDM0  = 0;
  localparam int EN_TCDM1  = 1;
  localparam int EN_TCDM2  = 2;
  localparam int EN_TCDM3  = 3;
  localparam int EN_APB    = 4;
  localparam int EN_EVENTS = 5;
  localparam int EN_UDMA   = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    HOLD   = 2'd2,
    SETTLE = 2'd3
  } efpga_seq_state_e;

endpackage

// File: rtl/efpga_pwr_seq.sv
// Sequences eFPGA soft resets and interface enables so enables are dropped and
// settled before a reset asserts, and resets settle before enables return.
`timescale 1ns/1ps
module efpga_pwr_seq
  import efpga_seq_pkg::*;
#(
  parameter int ISO_SETTLE_CYCLES = 4,
  parameter int RST_HOLD_CYCLES   = 16,
  parameter int CNT_WIDTH         = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NUM_EFPGA_RST-1:0] reset_type1_efpga_i,
  input  logic [NUM_EFPGA_EN-1:0]  enable_req_i,
  output logic [NUM_EFPGA_RST-1:0] efpga_rst_o,
  output logic [NUM_EFPGA_EN-1:0]  enable_o,
  output logic                     busy_o,
  output logic [1:0]               state_o
);

  if (ISO_SETTLE_CYCLES < 1 || ISO_SETTLE_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_iso
    $error("efpga_pwr_seq: ISO_SETTLE_CYCLES out of range");
  end
  if (RST_HOLD_CYCLES < 1 || RST_HOLD_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_hold
    $error("efpga_pwr_seq: RST_HOLD_CYCLES out of range");
  end
  if (NUM_EFPGA_EN != EN_UDMA + 1 || EN_TCDM0 != 0) begin : g_bad_en_map
    $error("efpga_pwr_seq: enable bit map inconsistent with enable width");
  end

  localparam logic [CNT_WIDTH-1:0] ISO_LOAD  = CNT_WIDTH'(ISO_SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(RST_HOLD_CYCLES - 1);

  logic [NUM_EFPGA_RST-1:0] rst_q;
  logic [NUM_EFPGA_EN-1:0]  en_q;

  efpga_seq_state_e         state_reg, state_next;
  logic [CNT_WIDTH-1:0]     cnt_reg, cnt_next;
  logic [NUM_EFPGA_RST-1:0] tgt_reg, tgt_next;
  logic [NUM_EFPGA_RST-1:0] efpga_rst_reg, efpga_rst_next;
  logic [NUM_EFPGA_EN-1:0]  enable_reg, enable_next;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    tgt_next       = tgt_reg;
    efpga_rst_next = efpga_rst_reg;
    enable_next    = enable_reg;

    case (state_reg)
      IDLE: begin
        if (|(rst_q & ~efpga_rst_reg)) begin
          enable_next = '0;
          tgt_next    = rst_q;
          cnt_next    = ISO_LOAD;
          state_next  = DRAIN;
        end else if (rst_q != efpga_rst_reg) begin
          // Pure release: enables are already low, only settle time is needed
          efpga_rst_next = rst_q;
          cnt_next       = ISO_LOAD;
          state_next     = SETTLE;
        end else begin
          enable_next = (efpga_rst_reg == '0) ? en_q : '0;
        end
      end

      DRAIN: begin
        if (cnt_reg == '0) begin
          // Target applied whole: bits released alongside an assertion go too
          efpga_rst_next = tgt_reg;
          cnt_next       = HOLD_LOAD;
          state_next     = HOLD;
        end else begin
          cnt_next = cnt_reg - CNT_WIDTH'(1);
        end
      end

      HOLD, SETTLE: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_WIDTH'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rst_q         <= '1;
      en_q          <= '0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      tgt_reg       <= '1;
      efpga_rst_reg <= '1;
      enable_reg    <= '0;
    end else begin
      rst_q         <= reset_type1_efpga_i;
      en_q          <= enable_req_i;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      tgt_reg       <= tgt_next;
      efpga_rst_reg <= efpga_rst_next;
      enable_reg    <= enable_next;
    end
  end

  assign efpga_rst_o = efpga_rst_reg;
  assign enable_o    = enable_reg;
  assign busy_o      = (state_reg != IDLE);
  assign state_o     = state_reg;

endmodule

// File: tb/tb_efpga_pwr_seq.sv
// Self-checking bench for efpga_pwr_seq: directed scenarios plus random traffic
// compared against a timeline-based reference model.
`timescale 1ns/1ps
module tb_efpga_pwr_seq;

  localparam int ISO   = 4;
  localparam int HOLDC = 16;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] req_rst;
  logic [6:0] req_en;
  logic [3:0] efpga_rst_o;
  logic [6:0] enable_o;
  logic       busy_o;
  logic [1:0] state_o;

  efpga_pwr_seq #(
    .ISO_SETTLE_CYCLES (ISO),
    .RST_HOLD_CYCLES   (HOLDC),
    .CNT_WIDTH         (8)
  ) dut (
    .HCLK                (HCLK),
    .HRESET              (HRESET),
    .reset_type1_efpga_i (req_rst),
    .enable_req_i        (req_en),
    .efpga_rst_o         (efpga_rst_o),
    .enable_o            (enable_o),
    .busy_o              (busy_o),
    .state_o             (state_o)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;

  // Reference model: absolute edge numbers of the next reset application and
  // of the moment the sequencer is free again.
  int         cyc, free_at, apply_at, kind;  // kind: 0 none, 1 assert, 2 release
  logic [3:0] m_rst, m_apply, m_rq;
  logic [6:0] m_en, m_eq;

  task automatic model_reset();
    cyc = 0; free_at = 0; apply_at = -1; kind = 0;
    m_rst = 4'hF; m_apply = 4'hF; m_rq = 4'hF;
    m_en = 7'h00; m_eq = 7'h00;
  endtask

  task automatic model_edge();
    logic [3:0] old_rq;
    logic [6:0] old_eq;
    old_rq = m_rq;
    old_eq = m_eq;
    cyc++;
    if (kind == 1 && cyc == apply_at) m_rst = m_apply;
    if (cyc > free_at) begin
      if (|(old_rq & ~m_rst)) begin
        m_en     = 7'h00;
        m_apply  = old_rq;
        apply_at = cyc + ISO;
        free_at  = cyc + ISO + HOLDC;
        kind     = 1;
      end else if (old_rq != m_rst) begin
        m_rst   = old_rq;
        free_at = cyc + ISO;
        kind    = 2;
      end else begin
        m_en = (m_rst == 4'h0) ? old_eq : 7'h00;
      end
    end
    m_rq = req_rst;
    m_eq = req_en;
  endtask

  function automatic int exp_state();
    if (cyc < free_at) begin
      if (kind == 1) return (cyc < apply_at) ? 1 : 2;
      return 3;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rst"},   32'(efpga_rst_o), 32'(m_rst));
    chk({tag, "_en"},    32'(enable_o),    32'(m_en));
    chk({tag, "_busy"},  32'(busy_o),      32'(cyc < free_at));
    chk({tag, "_state"}, 32'(state_o),     32'(exp_state()));
    chk({tag, "_iso"},   32'((|efpga_rst_o) && (|enable_o)), 32'(0));
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic [6:0] e);
    req_rst = r;
    req_en  = e;
    @(posedge HCLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic hit_reset(input string tag);
    #2;
    HRESET = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, "_async"}, 32'({efpga_rst_o, enable_o, busy_o, state_o}), 32'({4'hF, 7'h00, 1'b0, 2'd0}));
    #3;
    HRESET = 1'b0;
  endtask

  initial begin
    HRESET  = 1'b1;
    req_rst = 4'h0;
    req_en  = 7'h00;
    repeat (3) @(posedge HCLK);
    #1;
    model_reset();
    check_all("reset");
    HRESET = 1'b0;

    // Power-up release, then enables
    repeat (8) step("pwrup", 4'h0, 7'h00);
    chk("pwrup_rst_final", 32'(efpga_rst_o), 32'h0);
    repeat (3) step("en_on", 4'h0, 7'h7F);
    chk("en_on_final", 32'(enable_o), 32'h7F);

    // Reset assertion of domain 0
    repeat (24) step("assert", 4'h1, 7'h7F);
    chk("assert_final_rst", 32'(efpga_rst_o), 32'h1);
    chk("assert_final_en", 32'(enable_o), 32'h0);

    // Release, then re-assert and drop the request while in HOLD
    repeat (8) step("release", 4'h0, 7'h7F);
    repeat (8) step("mid_assert", 4'h1, 7'h7F);
    repeat (30) step("mid_drop", 4'h0, 7'h7F);
    chk("mid_final_en", 32'(enable_o), 32'h7F);

    // Enable-only change
    repeat (4) step("en_only", 4'h0, 7'h0F);
    chk("en_only_final", 32'(enable_o), 32'h0F);

    // Simultaneous assert/release
    repeat (25) step("rst2", 4'h2, 7'h0F);
    repeat (25) step("swap", 4'h1, 7'h0F);
    chk("swap_final_rst", 32'(efpga_rst_o), 32'h1);

    // Async reset in the middle of DRAIN
    repeat (25) step("rel_again", 4'h0, 7'h0F);
    repeat (3) step("drain", 4'h4, 7'h7F);
    chk("drain_state", 32'(state_o), 32'd1);
    hit_reset("rst_in_drain");
    repeat (10) step("post_rst", 4'h4, 7'h7F);
    repeat (10) step("post_rel", 4'h0, 7'h7F);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic [3:0] r;
      logic [6:0] e;
      r = req_rst;
      e = req_en;
      if ($urandom_range(0, 79) == 0) hit_reset("rnd_rst");
      if ($urandom_range(0, 9) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) e = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) r = 4'h0;
      step("rnd", r, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
